// File: rtl/router_pkg.sv
// Shared widths, FSM state type and header packing for the router packet transmitter.
package router_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_HEADER,
    TX_PAYLOAD,
    TX_PARITY
  } tx_state_t;

  function automatic logic [DATA_W-1:0] pack_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write, asynchronous read.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a payload, then emits header/payload/parity.
// Optional ROUTER_TX_CORRUPT_EN adds corrupt_parity to emit an inverted parity byte.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  output logic              ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              err_cmd
`ifdef ROUTER_TX_CORRUPT_EN
  ,
  input  logic              corrupt_parity
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] hdr_q, parity_q, parity_out, buf_rd_data;
  logic [LEN_W-1:0]  wr_q, rd_q, last_idx;
  logic              done_q, err_q;
  logic              cmd_legal, cmd_accept, buf_wr_en;

  assign cmd_legal  = (dest_addr != ILLEGAL_ADDR) && (pay_len != '0) && (pay_len <= MAX_LEN_L);
  assign cmd_accept = (state_q == TX_IDLE) && start && cmd_legal;
  assign last_idx   = hdr_q[DATA_W-1:ADDR_W] - ONE;
  assign buf_wr_en  = (state_q == TX_LOAD) && pay_valid;

  router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_idx  (wr_q),
    .wr_data (pay_data),
    .rd      (rd_q),
    .rd_data (buf_rd_data)
  );

`ifdef ROUTER_TX_CORRUPT_EN
  logic corrupt_q;

  always_ff @(posedge clock) begin
    if (reset)           corrupt_q <= 1'b0;
    else if (cmd_accept) corrupt_q <= corrupt_parity;
  end

  assign parity_out = corrupt_q ? ~parity_q : parity_q;
`else
  assign parity_out = parity_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      hdr_q    <= '0;
      parity_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == TX_PARITY) && !busy;
      err_q   <= (state_q == TX_IDLE) && start && !cmd_legal;
      unique case (state_q)
        TX_IDLE: if (cmd_accept) begin
          hdr_q    <= pack_hdr(pay_len, dest_addr);
          parity_q <= pack_hdr(pay_len, dest_addr);
          wr_q     <= '0;
          rd_q     <= '0;
        end
        TX_LOAD: if (pay_valid) begin
          parity_q <= parity_q ^ pay_data;
          wr_q     <= wr_q + ONE;
        end
        TX_PAYLOAD: if (!busy) rd_q <= rd_q + ONE;
        default: ;
      endcase
    end
  end

  // Outputs decode only from registered state, so no input reaches them combinationally.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    pay_ready = 1'b0;
    pkt_valid = 1'b0;
    data_out  = '0;
    unique case (state_q)
      TX_IDLE: begin
        ready = 1'b1;
        if (cmd_accept) state_d = TX_LOAD;
      end
      TX_LOAD: begin
        pay_ready = 1'b1;
        if (pay_valid && (wr_q == last_idx)) state_d = TX_HEADER;
      end
      TX_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = hdr_q;
        if (!busy) state_d = TX_PAYLOAD;
      end
      TX_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = buf_rd_data;
        if (!busy && (rd_q == last_idx)) state_d = TX_PARITY;
      end
      TX_PARITY: begin
        data_out = parity_out;
        if (!busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign done    = done_q;
  assign err_cmd = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes expected bytes, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
  logic       ready;
  logic [7:0] pay_data = '0;
  logic       pay_valid = 1'b0;
  logic       pay_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       err_cmd;
`ifdef ROUTER_TX_CORRUPT_EN
  logic       corrupt_parity = 1'b0;
`endif

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dest_addr (dest_addr),
    .pay_len   (pay_len),
    .ready     (ready),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_ready (pay_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .done      (done),
    .err_cmd   (err_cmd)
`ifdef ROUTER_TX_CORRUPT_EN
    ,
    .corrupt_parity (corrupt_parity)
`endif
  );

  always #5 clock = ~clock;

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         t_start = 0;
  bit         in_pkt = 1'b0;
  logic [8:0] exp_q [$];
  logic [7:0] pbytes [64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a byte is transferred at each edge with busy=0 while a packet is on the wire.
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset) begin
      in_pkt = 1'b0;
    end else if (!busy && (pkt_valid || in_pkt)) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL tx_byte: got %0h expected nothing", {pkt_valid, data_out});
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {pkt_valid, data_out}, e);
      end
      in_pkt = pkt_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_pkt(input logic [1:0] d, input int n, input bit corrupt);
    logic [7:0] h, p;
    h = {n[5:0], d};
    p = h;
    exp_q.push_back({1'b1, h});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, pbytes[i]});
      p ^= pbytes[i];
    end
    exp_q.push_back({1'b0, corrupt ? ~p : p});
  endtask

  task automatic issue(input logic [1:0] d, input logic [5:0] n, input bit corrupt);
    start     = 1'b1;
    dest_addr = d;
    pay_len   = n;
`ifdef ROUTER_TX_CORRUPT_EN
    corrupt_parity = corrupt;
`else
    if (corrupt) $display("corrupt request ignored in this build");
`endif
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap, output int lc);
    lc = 0;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        pay_valid = 1'b0;
        pay_data  = 8'hAA;
        if (pay_ready) lc++;
        tick();
      end
      pay_valid = 1'b1;
      pay_data  = pbytes[i];
      if (pay_ready) lc++;
      tick();
    end
    pay_valid = 1'b0;
    pay_data  = '0;
  endtask

  task automatic wait_done(input string name, output int rel);
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no done expected done within 300 cycles", name);
    end
    rel = cyc - t_start;
  endtask

  initial begin
    int lc, rel;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_ready", ready, 1);
    chk("rst_pay_ready", pay_ready, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_err_cmd", err_cmd, 0);

    // dest 2, 14 bytes 01..0E: header 3A, parity 35, done in cycle 31
    for (int i = 0; i < 14; i++) pbytes[i] = 8'(i + 1);
    exp_q.push_back(9'h13A);
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b1, pbytes[i]});
    exp_q.push_back(9'h035);
    issue(2'd2, 6'd14, 1'b0);
    feed(14, 1'b0, lc);
    chk("t1_load_cycles", lc, 14);
    wait_done("t1_done", rel);
    chk("t1_done_cycle", rel, 31);
    chk("t1_ready_at_done", ready, 1);
    chk("t1_queue_empty", exp_q.size(), 0);

    // back-to-back start in the done cycle, gap-free 4 bytes
    for (int i = 0; i < 4; i++) pbytes[i] = 8'hA0 + 8'(i);
    push_pkt(2'd1, 4, 1'b0);
    issue(2'd1, 6'd4, 1'b0);
    chk("b2b_done_pulse_once", done, 0);
    feed(4, 1'b0, lc);
    chk("b2b_load_cycles", lc, 4);
    wait_done("b2b_done", rel);
    chk("b2b_done_cycle", rel, 11);
    tick();

    // same packet with pay_valid every other cycle
    push_pkt(2'd1, 4, 1'b0);
    issue(2'd1, 6'd4, 1'b0);
    feed(4, 1'b1, lc);
    chk("gap_load_cycles", lc, 8);
    chk("gap_pay_ready_low", pay_ready, 0);
    wait_done("gap_done", rel);
    chk("gap_done_cycle", rel, 15);
    tick();

    // illegal commands
    issue(2'd3, 6'd5, 1'b0);
    chk("ill_addr_err", err_cmd, 1);
    chk("ill_addr_ready", ready, 1);
    tick();
    chk("ill_addr_err_once", err_cmd, 0);
    issue(2'd0, 6'd0, 1'b0);
    chk("ill_len_err", err_cmd, 1);
    chk("ill_len_ready", ready, 1);
    chk("ill_len_pkt_valid", pkt_valid, 0);
    tick();
    chk("ill_len_err_once", err_cmd, 0);
    chk("ill_pkt_valid", pkt_valid, 0);

    // 18 bytes, busy 3 cycles on byte 5 and 2 cycles on the last byte
    for (int i = 0; i < 18; i++) pbytes[i] = 8'h30 + 8'(i);
    push_pkt(2'd0, 18, 1'b0);
    issue(2'd0, 6'd18, 1'b0);
    feed(18, 1'b0, lc);
    for (int i = 0; i < 6; i++) tick();
    chk("busy_b5_first", data_out, pbytes[5]);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_b5_hold", {pkt_valid, data_out}, {1'b1, pbytes[5]});
      if (i == 2) busy = 1'b0;
    end
    tick();
    chk("busy_b6_next", data_out, pbytes[6]);
    for (int i = 0; i < 11; i++) tick();
    chk("busy_b17", data_out, pbytes[17]);
    busy = 1'b1;
    tick();
    chk("busy_last_hold1", {pkt_valid, data_out}, {1'b1, pbytes[17]});
    tick();
    chk("busy_last_hold2", {pkt_valid, data_out}, {1'b1, pbytes[17]});
    busy = 1'b0;
    tick();
    chk("busy_parity_pv", pkt_valid, 0);
    wait_done("busy_done", rel);
    chk("busy_queue_empty", exp_q.size(), 0);
    tick();

    // reset during payload byte 3
    for (int i = 0; i < 6; i++) pbytes[i] = 8'h50 + 8'(i);
    push_pkt(2'd1, 6, 1'b0);
    issue(2'd1, 6'd6, 1'b0);
    feed(6, 1'b0, lc);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_b3", data_out, pbytes[3]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("rst_mid_pkt_valid", pkt_valid, 0);
    chk("rst_mid_data_out", data_out, 8'h00);
    chk("rst_mid_ready", ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_done", done, 0);
      tick();
    end
    pbytes[0] = 8'hFF;
    exp_q.push_back(9'h104);
    exp_q.push_back(9'h1FF);
    exp_q.push_back(9'h0FB);
    issue(2'd0, 6'd1, 1'b0);
    feed(1, 1'b0, lc);
    wait_done("one_byte_done", rel);
    chk("one_byte_done_cycle", rel, 5);
    chk("one_byte_queue_empty", exp_q.size(), 0);
    tick();

`ifdef ROUTER_TX_CORRUPT_EN
    pbytes[0] = 8'h00;
    exp_q.push_back(9'h105);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h0FA);
    issue(2'd1, 6'd1, 1'b1);
    feed(1, 1'b0, lc);
    wait_done("corrupt_done", rel);
    chk("corrupt_queue_empty", exp_q.size(), 0);
    tick();
`endif

    for (int i = 0; i < 3; i++) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_ready", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
